// File: rtl/decode_regfile_hilo_pkg.sv
// Shared decode constants and helpers for the decode-stage register file
// and its HI/LO unit.
package decode_regfile_hilo_pkg;

  // Primary opcodes used by immediate extension and R-type decode
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;

  // SPECIAL funct codes touching HI/LO
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Mult/div tracking state: BUSY means a result is still owed to HI/LO
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // One-hot-ish flags for the HI/LO related instruction classes
  typedef struct packed {
    logic mfhi;
    logic mflo;
    logic mthi;
    logic mtlo;
    logic md;
  } hilo_op_t;

  // Classify an instruction by its HI/LO involvement
  function automatic hilo_op_t decode_hilo(input logic [5:0] opcode,
                                           input logic [5:0] funct);
    hilo_op_t op;
    logic     special;
    special = (opcode == OP_SPECIAL);
    op.mfhi = special && (funct == FN_MFHI);
    op.mflo = special && (funct == FN_MFLO);
    op.mthi = special && (funct == FN_MTHI);
    op.mtlo = special && (funct == FN_MTLO);
    op.md   = special && (funct == FN_MULT || funct == FN_MULTU ||
                          funct == FN_DIV  || funct == FN_DIVU);
    return op;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends
  function automatic logic is_zero_ext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_regfile_hilo_hilo_ctrl.sv
// HI/LO unit: holds HI and LO, tracks the outstanding mult/div, generates
// the issue pulse and stall, forwards a just-arrived result to mf* readers
// and flags unexpected completions.
//
// Handshake with the mult/div unit: md_issue is a single-cycle start pulse,
// asserted only for a valid, unstalled mult/div. The unit answers later with
// a single-cycle md_done carrying md_hi/md_lo. Only one operation may be in
// flight; a done pulse with nothing in flight is dropped and latches md_err.
module hilo_ctrl
  import decode_regfile_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  hilo_op_t          op,
  input  logic [DATA_W-1:0] rs_value,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  output logic [DATA_W-1:0] hi_value,
  output logic [DATA_W-1:0] lo_value,
  output logic              stall,
  output logic              md_issue,
  output logic              md_err,
  output md_state_t         md_state
);

  md_state_t         state_q;
  md_state_t         state_d;
  logic              pending;
  logic              md_accept;
  logic              hilo_user;
  logic              mthi_en;
  logic              mtlo_en;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  assign pending   = (state_q == MD_BUSY);
  assign md_accept = md_done & pending;
  assign hilo_user = op.mfhi | op.mflo | op.mthi | op.mtlo | op.md;
  assign mthi_en   = instr_valid & op.mthi & ~stall;
  assign mtlo_en   = instr_valid & op.mtlo & ~stall;
  assign md_state  = state_q;

  // A result arriving this cycle is visible to mf* immediately
  assign hi_value = md_accept ? md_hi : hi_q;
  assign lo_value = md_accept ? md_lo : lo_q;

  // Mult/div tracking state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Stall, issue and next tracking state; a new issue outranks completion
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    md_issue = 1'b0;
    stall    = instr_valid & pending & ~md_done & hilo_user;
    md_issue = reset & instr_valid & op.md & ~stall;
    if (md_issue)       state_d = MD_BUSY;
    else if (md_accept) state_d = MD_IDLE;
  end

  // HI/LO update: an mt* in the done cycle is younger than the result, so it wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (md_accept) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end
      if (mthi_en) hi_q <= rs_value;
      if (mtlo_en) lo_q <= rs_value;
    end
  end

  // Sticky error for a completion nobody asked for
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   md_err <= 1'b0;
    else if (md_done && !pending) md_err <= 1'b1;
  end

endmodule

// File: rtl/decode_regfile_hilo.sv
// Decode-stage register file: instruction field decode, writeback mux,
// write-through read ports, immediate extension and the HI/LO unit.
module decode_regfile_hilo
  import decode_regfile_hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              RegDst,
  input  logic              Jal,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] opcplus4,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] Sign_extend,
  output logic              md_issue,
  output logic              stall,
  output logic              md_err,
  output md_state_t         md_state
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RA_ADDR  = ADDR_W'(NUM_REGS - 1);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] rs_a;
  logic [ADDR_W-1:0] rt_a;
  logic [ADDR_W-1:0] rd_a;
  hilo_op_t          op;
  logic              unused_shamt;

  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] hi_value;
  logic [DATA_W-1:0] lo_value;

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign imm          = instruction[15:0];
  assign rs_a         = ADDR_W'(instruction[25:21]);
  assign rt_a         = ADDR_W'(instruction[20:16]);
  assign rd_a         = ADDR_W'(instruction[15:11]);
  assign op           = decode_hilo(opcode, funct);
  assign unused_shamt = ^instruction[10:6];

  // Immediate extension
  always_comb begin
    Sign_extend = {{(DATA_W-16){imm[15]}}, imm};
    if (is_zero_ext(opcode)) Sign_extend = {{(DATA_W-16){1'b0}}, imm};
  end

  // Writeback select: mf* moves take over the port, else Jal > MemtoReg > ALU
  always_comb begin
    wen   = 1'b0;
    waddr = '0;
    wdata = '0;
    if (op.mfhi || op.mflo) begin
      waddr = rd_a;
      wdata = op.mfhi ? hi_value : lo_value;
      wen   = reset & instr_valid & ~stall & (rd_a != '0);
    end else begin
      waddr = Jal ? RA_ADDR : (RegDst ? rd_a : rt_a);
      wdata = Jal ? opcplus4 : (MemtoReg ? mem_data : ALU_result);
      wen   = reset & instr_valid & RegWrite & ~stall & (waddr != '0);
    end
  end

  // Register storage; reg0 is never targeted because wen excludes address 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with write-through of the data being written this cycle
  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (rs_a != '0) read_data_1 = (wen && waddr == rs_a) ? wdata : regs[rs_a];
    if (rt_a != '0) read_data_2 = (wen && waddr == rt_a) ? wdata : regs[rt_a];
  end

  hilo_ctrl #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .op          (op),
    .rs_value    (read_data_1),
    .md_done     (md_done),
    .md_hi       (md_hi),
    .md_lo       (md_lo),
    .hi_value    (hi_value),
    .lo_value    (lo_value),
    .stall       (stall),
    .md_issue    (md_issue),
    .md_err      (md_err),
    .md_state    (md_state)
  );

endmodule
